ervp_latency_monitor_scheduler: RTL and testbench
=================================================

Name: ervp_latency_monitor_scheduler

Overview:
- Shares one latency counter, with timeout detection, among NUM_CH requesters.
- Each requester posts a start pulse. The scheduler grants channels one at a time in round-robin order, counts cycles until that channel's done pulse or the timeout, and reports the result.
- Keeps per-channel maximum latency, sticky per-channel timeout flags and a global timeout-event count.
- Sits between accelerator command ports and the debug/status register block.

Parameters:
NUM_CH, 4, number of requester channels (2..16)
BW_COUNT, 16, latency counter width
TIMEOUT, 500, cycle count at which a measurement is aborted as a timeout (must be < 2^BW_COUNT)
BW_EVENT, 16, timeout-event counter width

Ports:
clk  input  1  clock
rstnn  input  1  synchronous active-low reset, sampled on rising clk
enable  input  1  global advance enable; 0 freezes FSM, counter and statistics
ch_req  input  NUM_CH  per-channel start pulse
ch_done  input  NUM_CH  per-channel completion pulse
cfg_clear  input  1  clears statistics (max_latency, timeout_flag, timeout_events)
busy  output  1  1 while in MEASURE or REPORT
active_ch  output  clog2(NUM_CH)  granted channel (valid while busy)
result_valid  output  1  one-cycle pulse in REPORT
result_ch  output  clog2(NUM_CH)  channel of current result
result_latency  output  BW_COUNT  measured latency
result_timeout  output  1  result was a timeout abort
timeout_flag  output  NUM_CH  sticky per-channel timeout flag
timeout_events  output  BW_EVENT  saturating count of timeouts
max_latency  output  NUM_CH*BW_COUNT  per-channel maximum; channel i occupies bits [i*BW_COUNT +: BW_COUNT]

Behaviour:
- Reset (rstnn=0 at a rising edge): every output and register is 0, FSM in IDLE, pending cleared, round-robin pointer at 0. Applies mid-measurement; the in-flight measurement is discarded without a report.
- Pending capture (independent of enable): ch_req[i]=1 sets pending[i]. A set in the same cycle as a clear for that channel wins. Requests to an already-pending channel merge.
- IDLE:
  - If enable and any pending bit is set, grant the first pending channel at or after rr_ptr, wrapping around.
  - On grant: clear that pending bit, set active_ch, counter=0, rr_ptr=grant+1 (mod NUM_CH), go to MEASURE. Grant takes 1 cycle.
- MEASURE, each enable=1 cycle, priority order:
  1. ch_done[active_ch]: latency=counter, timeout=0, go to REPORT.
  2. Else if counter>=TIMEOUT: latency=counter, timeout=1, go to REPORT.
  3. Else counter+1.
  - ch_done on other channels is ignored. Done in the first MEASURE cycle reports latency 0.
  - Done and counter==TIMEOUT in the same cycle reports a non-timeout.
- REPORT (1 cycle, unaffected by enable):
  - result_valid=1.
  - max_latency[ch] updates if latency > stored value.
  - On timeout: timeout_flag[ch]=1, timeout_events+1, saturating at all-ones.
  - Returns to IDLE. result_ch, result_latency and result_timeout hold until the next REPORT.
- cfg_clear: in any cycle, zeroes the statistics and takes priority over a same-cycle REPORT update. It does not affect pending, FSM state or result_* outputs.
- enable=0 in IDLE/MEASURE: state and counter hold; ch_done in that cycle is lost.
- Widths: all comparisons unsigned. counter cannot overflow because TIMEOUT < 2^BW_COUNT.

Decomposition:
- Package ervp_latency_monitor_pkg holds:
  - FSM state encoding: IDLE=0, MEASURE=1, REPORT=2.
  - Channel-index width function.
  - Saturating-increment helper.
- Sub-module ervp_rr_pick: combinational round-robin selector.
  - Inputs: pending vector, rr_ptr.
  - Outputs: found, index.

Test Plan:
- Single request: ch_req[1] pulse, ch_done[1] 3 enabled cycles after MEASURE entry -> result_valid once, result_ch=1, result_latency=3, result_timeout=0, max_latency ch1=3.
- Round-robin: ch_req=4'b1111 at once, each done after 2 cycles -> grant order 0,1,2,3. Then re-request 0 and 2 -> order 0,2.
- Timeout: TIMEOUT=10, ch_req[2], no done -> REPORT at counter=10, result_timeout=1, timeout_flag=4'b0100, timeout_events=1. Done at counter=10 instead -> result_timeout=0.
- Enable freeze: enable=0 for 5 cycles mid-MEASURE -> counter holds, reported latency excludes the frozen cycles. A ch_req during the freeze is still queued.
- Clear vs report: cfg_clear in the same cycle as a timeout REPORT -> flags, events and max all 0 afterwards; result_timeout=1 still shown.
- Reset mid-MEASURE: rstnn=0 for 1 cycle -> busy=0, no result_valid, all statistics 0, the later request is granted from rr_ptr=0.

Source files
------------

// File: rtl/ervp_latency_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ervp_latency_monitor_pkg
//  Purpose  : Shared types and helpers for the round-robin latency monitor.
//             - state_t   : scheduler FSM encoding (IDLE/MEASURE/REPORT)
//             - ch_width  : width of a channel index for a given channel count
//             - sat_inc   : increment that sticks at all-ones for a given width
//  Revision : 1.0 - initial release
// ============================================================================
package ervp_latency_monitor_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_REPORT  = 2'd2
    } state_t;

    // A single-channel build still needs a 1-bit index so that ports never
    // collapse to zero width.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Saturating increment for counters up to 32 bits wide; callers cast the
    // result back to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = 32'hFFFF_FFFF >> (32 - width);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ervp_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : ervp_rr_pick
//  Purpose  : Combinational round-robin selector. Returns the first set bit
//             of the pending vector at or after rr_ptr, wrapping around.
//  Ports    : pending [NUM_CH]  - request vector
//             rr_ptr  [CW]      - search start position (< NUM_CH)
//             found             - at least one pending bit is set
//             index   [CW]      - selected channel (0 when nothing found)
//  Revision : 1.0 - initial release
// ============================================================================
module ervp_rr_pick
    import ervp_latency_monitor_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]           pending,
    input  logic [ch_width(NUM_CH)-1:0] rr_ptr,
    output logic                        found,
    output logic [ch_width(NUM_CH)-1:0] index
);

    localparam int c_chw = ch_width(NUM_CH);

    logic [c_chw:0]   w_sum;
    logic [c_chw-1:0] w_idx;

    // Walk offsets from the far end back to zero so the smallest offset
    // (closest to rr_ptr) is the last writer and therefore wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        w_sum = '0;
        w_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_sum = {1'b0, rr_ptr} + (c_chw + 1)'(k);
            if (w_sum >= (c_chw + 1)'(NUM_CH)) begin
                w_sum = w_sum - (c_chw + 1)'(NUM_CH);
            end
            w_idx = w_sum[c_chw-1:0];
            if (pending[w_idx]) begin
                found = 1'b1;
                index = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ervp_latency_monitor_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ervp_latency_monitor_scheduler
//  Purpose  : One latency counter with timeout detection shared round-robin
//             among NUM_CH requesters. Tracks per-channel maximum latency,
//             sticky per-channel timeout flags and a saturating timeout count.
//  Ports    : clk, rstnn (sync, active-low)
//             enable          - 0 freezes FSM, counter and statistics
//             ch_req/ch_done  - per-channel start / completion pulses
//             cfg_clear       - zero max_latency, timeout_flag, timeout_events
//             busy, active_ch - measurement in progress / granted channel
//             result_*        - last report (valid pulses for one cycle)
//             timeout_flag, timeout_events, max_latency - statistics
//  Revision : 1.0 - initial release
// ============================================================================
module ervp_latency_monitor_scheduler
    import ervp_latency_monitor_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int BW_COUNT = 16,
    parameter int TIMEOUT  = 500,
    parameter int BW_EVENT = 16
) (
    input  logic                         clk,
    input  logic                         rstnn,
    input  logic                         enable,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_done,
    input  logic                         cfg_clear,
    output logic                         busy,
    output logic [ch_width(NUM_CH)-1:0]  active_ch,
    output logic                         result_valid,
    output logic [ch_width(NUM_CH)-1:0]  result_ch,
    output logic [BW_COUNT-1:0]          result_latency,
    output logic                         result_timeout,
    output logic [NUM_CH-1:0]            timeout_flag,
    output logic [BW_EVENT-1:0]          timeout_events,
    output logic [NUM_CH*BW_COUNT-1:0]   max_latency
);

    localparam int                  c_chw     = ch_width(NUM_CH);
    localparam logic [BW_COUNT-1:0] c_timeout = BW_COUNT'(TIMEOUT);

    state_t                r_state;
    logic [NUM_CH-1:0]     r_pending;
    logic [c_chw-1:0]      r_rr_ptr;
    logic [c_chw-1:0]      r_active_ch;
    logic [BW_COUNT-1:0]   r_counter;
    logic                  r_result_valid;
    logic [c_chw-1:0]      r_result_ch;
    logic [BW_COUNT-1:0]   r_result_latency;
    logic                  r_result_timeout;
    logic [BW_EVENT-1:0]   r_timeout_events;

    logic                  w_found;
    logic [c_chw-1:0]      w_grant;
    logic                  w_grant_fire;
    logic [NUM_CH-1:0]     w_grant_mask;
    logic [c_chw-1:0]      w_next_ptr;
    logic                  w_report;

    // ------------------------------------------------------------------
    // Round-robin selection over the pending vector
    // ------------------------------------------------------------------
    ervp_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .pending (r_pending),
        .rr_ptr  (r_rr_ptr),
        .found   (w_found),
        .index   (w_grant)
    );

    assign w_grant_fire = (r_state == S_IDLE) && enable && w_found;
    assign w_grant_mask = w_grant_fire ? (NUM_CH'(1) << w_grant) : '0;
    assign w_next_ptr   = (w_grant == c_chw'(NUM_CH - 1)) ? '0 : w_grant + c_chw'(1);
    assign w_report     = (r_state == S_REPORT);

    // Pending capture runs regardless of enable; a new request for the
    // channel being granted this cycle survives the grant's clear.
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant_mask) | ch_req;
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM with registered result outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            r_state          <= S_IDLE;
            r_rr_ptr         <= '0;
            r_active_ch      <= '0;
            r_counter        <= '0;
            r_result_valid   <= 1'b0;
            r_result_ch      <= '0;
            r_result_latency <= '0;
            r_result_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_result_valid <= 1'b0;
                    if (w_grant_fire) begin
                        r_active_ch <= w_grant;
                        r_counter   <= '0;
                        r_rr_ptr    <= w_next_ptr;
                        r_state     <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (enable) begin
                        // Completion outranks timeout, so a done arriving
                        // exactly at TIMEOUT is still a normal result.
                        if (ch_done[r_active_ch]) begin
                            r_result_ch      <= r_active_ch;
                            r_result_latency <= r_counter;
                            r_result_timeout <= 1'b0;
                            r_result_valid   <= 1'b1;
                            r_state          <= S_REPORT;
                        end else if (r_counter >= c_timeout) begin
                            r_result_ch      <= r_active_ch;
                            r_result_latency <= r_counter;
                            r_result_timeout <= 1'b1;
                            r_result_valid   <= 1'b1;
                            r_state          <= S_REPORT;
                        end else begin
                            r_counter <= r_counter + BW_COUNT'(1);
                        end
                    end
                end
                S_REPORT: begin
                    r_result_valid <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_result_valid <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Statistics: the REPORT cycle presents the finished result on the
    // result_* registers, so statistics fold it in from there. cfg_clear
    // overrides a same-cycle update.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            r_timeout_events <= '0;
        end else if (cfg_clear) begin
            r_timeout_events <= '0;
        end else if (w_report && r_result_timeout) begin
            r_timeout_events <= BW_EVENT'(sat_inc(32'(r_timeout_events), BW_EVENT));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
        logic [BW_COUNT-1:0] r_max;
        logic                r_flag;
        logic                w_hit;

        assign w_hit = w_report && (r_result_ch == c_chw'(i));

        always_ff @(posedge clk) begin
            if (!rstnn) begin
                r_max  <= '0;
                r_flag <= 1'b0;
            end else if (cfg_clear) begin
                r_max  <= '0;
                r_flag <= 1'b0;
            end else if (w_hit) begin
                if (r_result_latency > r_max) begin
                    r_max <= r_result_latency;
                end
                if (r_result_timeout) begin
                    r_flag <= 1'b1;
                end
            end
        end

        assign max_latency[i*BW_COUNT +: BW_COUNT] = r_max;
        assign timeout_flag[i]                     = r_flag;
    end

    assign busy           = (r_state == S_MEASURE) || (r_state == S_REPORT);
    assign active_ch      = r_active_ch;
    assign result_valid   = r_result_valid;
    assign result_ch      = r_result_ch;
    assign result_latency = r_result_latency;
    assign result_timeout = r_result_timeout;
    assign timeout_events = r_timeout_events;

endmodule
`default_nettype wire

// File: tb/tb_ervp_latency_monitor_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ervp_latency_monitor_scheduler
//  Purpose  : Directed self-checking bench for the latency monitor scheduler.
//             Built with TIMEOUT=10 and a 2-bit event counter so timeouts and
//             event-count saturation are reached in a few cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ervp_latency_monitor_scheduler;

    localparam int NUM_CH   = 4;
    localparam int BW_COUNT = 16;
    localparam int TIMEOUT  = 10;
    localparam int BW_EVENT = 2;

    logic                       clk       = 1'b0;
    logic                       rstnn     = 1'b0;
    logic                       enable    = 1'b0;
    logic [NUM_CH-1:0]          ch_req    = '0;
    logic [NUM_CH-1:0]          ch_done   = '0;
    logic                       cfg_clear = 1'b0;
    logic                       busy;
    logic [1:0]                 active_ch;
    logic                       result_valid;
    logic [1:0]                 result_ch;
    logic [BW_COUNT-1:0]        result_latency;
    logic                       result_timeout;
    logic [NUM_CH-1:0]          timeout_flag;
    logic [BW_EVENT-1:0]        timeout_events;
    logic [NUM_CH*BW_COUNT-1:0] max_latency;

    int err_count = 0;
    int chk_count = 0;

    ervp_latency_monitor_scheduler #(
        .NUM_CH   (NUM_CH),
        .BW_COUNT (BW_COUNT),
        .TIMEOUT  (TIMEOUT),
        .BW_EVENT (BW_EVENT)
    ) dut (
        .clk            (clk),
        .rstnn          (rstnn),
        .enable         (enable),
        .ch_req         (ch_req),
        .ch_done        (ch_done),
        .cfg_clear      (cfg_clear),
        .busy           (busy),
        .active_ch      (active_ch),
        .result_valid   (result_valid),
        .result_ch      (result_ch),
        .result_latency (result_latency),
        .result_timeout (result_timeout),
        .timeout_flag   (timeout_flag),
        .timeout_events (timeout_events),
        .max_latency    (max_latency)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [NUM_CH-1:0] mask);
        ch_req = mask;
        tick();
        ch_req = '0;
    endtask

    // Entered in IDLE with the channel already pending: one cycle to grant,
    // n MEASURE cycles, then done -> REPORT with latency n, then back to IDLE.
    task automatic serve(input int ch, input int n, input logic [NUM_CH-1:0] req_at_grant);
        ch_req = req_at_grant;
        tick();
        ch_req = '0;
        check_eq("grant_busy", busy, 1);
        check_eq("grant_ch", active_ch, ch);
        repeat (n) begin
            tick();
            check_eq("measure_no_valid", result_valid, 0);
        end
        ch_done = NUM_CH'(1) << ch;
        tick();
        ch_done = '0;
        check_eq("report_valid", result_valid, 1);
        check_eq("report_ch", result_ch, ch);
        check_eq("report_latency", result_latency, n);
        check_eq("report_timeout", result_timeout, 0);
        tick();
        check_eq("idle_valid_low", result_valid, 0);
    endtask

    // Entered in IDLE with the channel pending; returns in the REPORT cycle
    // of a timeout abort. Done pulses on the other channels are injected
    // mid-measurement and must be ignored.
    task automatic measure_timeout(input int ch);
        tick();
        check_eq("to_grant_ch", active_ch, ch);
        for (int i = 0; i < TIMEOUT; i++) begin
            ch_done = (i == 5) ? ~(NUM_CH'(1) << ch) : '0;
            tick();
        end
        ch_done = '0;
        check_eq("to_not_yet", result_valid, 0);
        tick();
        check_eq("to_valid", result_valid, 1);
        check_eq("to_ch", result_ch, ch);
        check_eq("to_latency", result_latency, TIMEOUT);
        check_eq("to_flag", result_timeout, 1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        rstnn  = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", result_valid, 0);
        check_eq("rst_active", active_ch, 0);
        check_eq("rst_res_ch", result_ch, 0);
        check_eq("rst_res_lat", result_latency, 0);
        check_eq("rst_res_to", result_timeout, 0);
        check_eq("rst_flags", timeout_flag, 0);
        check_eq("rst_events", timeout_events, 0);
        check_eq("rst_max", max_latency, 0);
        rstnn = 1'b1;
        tick();

        // ---------------- round-robin ----------------
        pulse_req(4'b1111);
        serve(0, 2, '0);
        serve(1, 2, '0);
        serve(2, 2, '0);
        serve(3, 2, '0);
        pulse_req(4'b0101);
        serve(0, 2, '0);
        serve(2, 2, '0);

        // ---------------- single request ----------------
        pulse_req(4'b0010);
        serve(1, 3, '0);
        check_eq("max_ch1", max_latency[31:16], 3);
        check_eq("max_all", max_latency, 64'h0002_0002_0003_0002);

        // ---------------- timeout ----------------
        pulse_req(4'b0100);
        measure_timeout(2);
        tick();
        check_eq("to_flags", timeout_flag, 4'b0100);
        check_eq("to_events", timeout_events, 1);
        check_eq("to_max_ch2", max_latency[47:32], TIMEOUT);

        // done exactly at counter==TIMEOUT is a normal completion
        pulse_req(4'b0010);
        serve(1, TIMEOUT, '0);
        check_eq("edge_events", timeout_events, 1);
        check_eq("edge_flags", timeout_flag, 4'b0100);
        check_eq("edge_max_ch1", max_latency[31:16], TIMEOUT);

        // ---------------- enable freeze ----------------
        pulse_req(4'b1000);
        tick();
        check_eq("frz_grant", active_ch, 3);
        tick();
        tick();
        enable = 1'b0;
        ch_req = 4'b0001;
        tick();
        ch_req  = '0;
        ch_done = 4'b1000;
        tick();
        ch_done = '0;
        tick();
        tick();
        tick();
        check_eq("frz_busy", busy, 1);
        check_eq("frz_no_valid", result_valid, 0);
        enable = 1'b1;
        tick();
        ch_done = 4'b1000;
        tick();
        ch_done = '0;
        check_eq("frz_valid", result_valid, 1);
        check_eq("frz_latency", result_latency, 3);
        check_eq("frz_ch", result_ch, 3);
        tick();
        serve(0, 1, '0);

        // ---------------- clear vs report ----------------
        pulse_req(4'b0100);
        measure_timeout(2);
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        check_eq("clr_flags", timeout_flag, 0);
        check_eq("clr_events", timeout_events, 0);
        check_eq("clr_max", max_latency, 0);
        check_eq("clr_res_to", result_timeout, 1);
        check_eq("clr_res_lat", result_latency, TIMEOUT);
        check_eq("clr_res_ch", result_ch, 2);

        // ---------------- event counter saturation ----------------
        for (int k = 1; k <= 4; k++) begin
            pulse_req(4'b1000);
            measure_timeout(3);
            tick();
            check_eq("sat_events", timeout_events, (k > 3) ? 3 : k);
        end
        check_eq("sat_flags", timeout_flag, 4'b1000);
        check_eq("sat_max", max_latency, 64'h000A_0000_0000_0000);

        // ---------------- reset mid-MEASURE ----------------
        pulse_req(4'b0010);
        tick();
        check_eq("mrst_grant", active_ch, 1);
        tick();
        tick();
        tick();
        rstnn = 1'b0;
        tick();
        rstnn = 1'b1;
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_valid", result_valid, 0);
        check_eq("mrst_flags", timeout_flag, 0);
        check_eq("mrst_events", timeout_events, 0);
        check_eq("mrst_max", max_latency, 0);
        check_eq("mrst_res_lat", result_latency, 0);
        tick();
        tick();
        check_eq("mrst_idle_busy", busy, 0);
        check_eq("mrst_idle_valid", result_valid, 0);
        // rr pointer back at 0: ch1 must win over ch2; done on first cycle = 0
        pulse_req(4'b0110);
        serve(1, 0, '0);
        serve(2, 1, '0);

        // ---------------- request during own grant is kept ----------------
        pulse_req(4'b0001);
        serve(0, 1, 4'b0001);
        serve(0, 0, '0);
        tick();
        check_eq("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", err_count, chk_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
